cdb_alu_transmitter: RTL and testbench

CDB_ALU_TRANSMITTER -- requirements
Module: cdb_alu_transmitter

---
 rtl/cdb_alu_transmitter_pkg.sv | 33 +++
 rtl/cdb_result_fifo.sv | 76 +++++++
 rtl/cdb_alu_transmitter.sv | 105 ++++++++++
 tb/tb_cdb_alu_transmitter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_alu_transmitter_pkg.sv
// Shared definitions for the ALU-to-CDB result transmitter: field widths taken
// from the core header constants and the packed payload carried through the buffer.
package cdb_alu_transmitter_pkg;

    localparam int CORE_REGNAME_W       = 6;
    localparam int CORE_FLAGS_REGNAME_W = 4;
    localparam int CORE_FLAGS_W         = 5;
    localparam int CORE_COMMIT_TAG_W    = 6;
    localparam int CORE_DATA_W          = 32;

    localparam int EX_POINTER_W = 4;
    localparam int INFO_COUNT_W = 4;

    typedef struct packed {
        logic                            writeback;
        logic [CORE_REGNAME_W-1:0]       destination_regname;
        logic [CORE_DATA_W-1:0]          data;
        logic                            flags_opt_valid;
        logic [CORE_FLAGS_REGNAME_W-1:0] flags_regname;
        logic [CORE_FLAGS_W-1:0]         flags;
        logic [CORE_COMMIT_TAG_W-1:0]    commit_tag;
    } cdb_payload_t;

    localparam int CDB_PAYLOAD_W = $bits(cdb_payload_t);

    // The execution pointer is a free-running 4-bit sequence number; 15 rolls to 0.
    function automatic logic [EX_POINTER_W-1:0] ex_pointer_next(
        input logic [EX_POINTER_W-1:0] ptr
    );
        return EX_POINTER_W'(ptr + 1'b1);
    endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// In-order result buffer between the ALU and the CDB. Head data reads as zero
// while empty so the broadcast payload never shows stale entries.
module cdb_result_fifo #(
    parameter int P_WIDTH = 55,
    parameter int P_DEPTH = 4
) (
    input  logic                       iCLOCK,
    input  logic                       iRESET,
    input  logic                       iFLUSH,
    input  logic                       iPUSH,
    input  logic [P_WIDTH-1:0]         iPUSH_DATA,
    input  logic                       iPOP,
    output logic [P_WIDTH-1:0]         oHEAD_DATA,
    output logic [$clog2(P_DEPTH):0]   oCOUNT,
    output logic                       oFULL,
    output logic                       oEMPTY
);

    localparam int PTR_W = $clog2(P_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(P_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(P_DEPTH);

    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_IDX) ? '0 : PTR_W'(ptr + 1'b1);
    endfunction

    assign oFULL  = (count == FULL_COUNT);
    assign oEMPTY = (count == '0);
    assign oCOUNT = count;

    // Requests against a full or empty buffer are ignored here as well, so the
    // storage stays consistent whatever the caller does.
    assign do_push = iPUSH && !oFULL  && !iFLUSH;
    assign do_pop  = iPOP  && !oEMPTY && !iFLUSH;

    always_ff @(posedge iCLOCK) begin
        if (do_push) begin
            mem[wr_ptr] <= iPUSH_DATA;
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (iFLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= CNT_W'(count + 1'b1);
                2'b01:   count <= CNT_W'(count - 1'b1);
                default: count <= count;
            endcase
        end
    end

    assign oHEAD_DATA = oEMPTY ? '0 : mem[rd_ptr];

endmodule

// File: rtl/cdb_alu_transmitter.sv
// ALU result channel onto the common data bus: buffers results in order and
// broadcasts the oldest one whenever the CDB arbiter grants this channel.
module cdb_alu_transmitter
    import cdb_alu_transmitter_pkg::*;
#(
    parameter int P_DEPTH = 4
) (
    input  logic                            iCLOCK,
    input  logic                            iRESET,
    input  logic                            iFLUSH,
    input  logic                            iISSUE_VALID,
    output logic [EX_POINTER_W-1:0]         oEX_EXECUTION_POINTER,
    input  logic                            iRESULT_VALID,
    output logic                            oRESULT_BUSY,
    input  logic                            iRESULT_WRITEBACK,
    input  logic [CORE_REGNAME_W-1:0]       iRESULT_DESTINATION_REGNAME,
    input  logic [CORE_DATA_W-1:0]          iRESULT_DATA,
    input  logic                            iRESULT_FLAGS_OPT_VALID,
    input  logic [CORE_FLAGS_REGNAME_W-1:0] iRESULT_FLAGS_REGNAME,
    input  logic [CORE_FLAGS_W-1:0]         iRESULT_FLAGS,
    input  logic [CORE_COMMIT_TAG_W-1:0]    iRESULT_COMMIT_TAG,
    input  logic                            iCDB_GRANT,
    output logic                            oCDB_VALID,
    output logic                            oCDB_WRITEBACK,
    output logic [CORE_REGNAME_W-1:0]       oCDB_DESTINATION_REGNAME,
    output logic [CORE_DATA_W-1:0]          oCDB_DATA,
    output logic                            oCDB_FLAGS_OPT_VALID,
    output logic [CORE_FLAGS_REGNAME_W-1:0] oCDB_FLAGS_REGNAME,
    output logic [CORE_FLAGS_W-1:0]         oCDB_FLAGS,
    output logic [CORE_COMMIT_TAG_W-1:0]    oCDB_COMMIT_TAG,
    output logic [INFO_COUNT_W-1:0]         oINFO_COUNT
);

    localparam int CNT_W = $clog2(P_DEPTH) + 1;

    cdb_payload_t      push_payload;
    cdb_payload_t      head_payload;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [EX_POINTER_W-1:0] ex_pointer;

    // Handshakes: a result transfers in a cycle where iRESULT_VALID=1 and
    // oRESULT_BUSY=0 (busy is the inverted ready, driven only by occupancy);
    // a broadcast transfers in every cycle where oCDB_VALID=1, which already
    // includes the grant, so the consumer has no way to stall it. iFLUSH
    // cancels both transfers in its cycle.
    assign oRESULT_BUSY = fifo_full;
    assign push         = iRESULT_VALID && !fifo_full && !iFLUSH;
    assign oCDB_VALID   = !fifo_empty && iCDB_GRANT && !iFLUSH;
    assign pop          = oCDB_VALID;

    always_comb begin
        push_payload                     = '0;
        push_payload.writeback           = iRESULT_WRITEBACK;
        push_payload.destination_regname = iRESULT_DESTINATION_REGNAME;
        push_payload.data                = iRESULT_DATA;
        push_payload.flags_opt_valid     = iRESULT_FLAGS_OPT_VALID;
        push_payload.flags_regname       = iRESULT_FLAGS_REGNAME;
        push_payload.flags               = iRESULT_FLAGS;
        push_payload.commit_tag          = iRESULT_COMMIT_TAG;
    end

    cdb_result_fifo #(
        .P_WIDTH (CDB_PAYLOAD_W),
        .P_DEPTH (P_DEPTH)
    ) u_result_fifo (
        .iCLOCK     (iCLOCK),
        .iRESET     (iRESET),
        .iFLUSH     (iFLUSH),
        .iPUSH      (push),
        .iPUSH_DATA (push_payload),
        .iPOP       (pop),
        .oHEAD_DATA (head_payload),
        .oCOUNT     (fifo_count),
        .oFULL      (fifo_full),
        .oEMPTY     (fifo_empty)
    );

    // Flags fields pass through untouched so flags-only results keep WRITEBACK=0.
    assign oCDB_WRITEBACK           = head_payload.writeback;
    assign oCDB_DESTINATION_REGNAME = head_payload.destination_regname;
    assign oCDB_DATA                = head_payload.data;
    assign oCDB_FLAGS_OPT_VALID     = head_payload.flags_opt_valid;
    assign oCDB_FLAGS_REGNAME       = head_payload.flags_regname;
    assign oCDB_FLAGS               = head_payload.flags;
    assign oCDB_COMMIT_TAG          = head_payload.commit_tag;

    assign oINFO_COUNT = INFO_COUNT_W'(fifo_count);

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            ex_pointer <= '0;
        end else if (iFLUSH) begin
            ex_pointer <= '0;
        end else if (iISSUE_VALID) begin
            ex_pointer <= ex_pointer_next(ex_pointer);
        end
    end

    assign oEX_EXECUTION_POINTER = ex_pointer;

endmodule

// File: tb/tb_cdb_alu_transmitter.sv
// Self-checking bench for cdb_alu_transmitter: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_cdb_alu_transmitter;

    localparam int DEPTH = 4;
    localparam int PW    = 55;

    logic        iCLOCK = 1'b0;
    logic        iRESET;
    logic        iFLUSH;
    logic        iISSUE_VALID;
    logic [3:0]  oEX_EXECUTION_POINTER;
    logic        iRESULT_VALID;
    logic        oRESULT_BUSY;
    logic        iRESULT_WRITEBACK;
    logic [5:0]  iRESULT_DESTINATION_REGNAME;
    logic [31:0] iRESULT_DATA;
    logic        iRESULT_FLAGS_OPT_VALID;
    logic [3:0]  iRESULT_FLAGS_REGNAME;
    logic [4:0]  iRESULT_FLAGS;
    logic [5:0]  iRESULT_COMMIT_TAG;
    logic        iCDB_GRANT;
    logic        oCDB_VALID;
    logic        oCDB_WRITEBACK;
    logic [5:0]  oCDB_DESTINATION_REGNAME;
    logic [31:0] oCDB_DATA;
    logic        oCDB_FLAGS_OPT_VALID;
    logic [3:0]  oCDB_FLAGS_REGNAME;
    logic [4:0]  oCDB_FLAGS;
    logic [5:0]  oCDB_COMMIT_TAG;
    logic [3:0]  oINFO_COUNT;

    // Payload layout: {wb, dest, data, flags_opt_valid, flags_regname, flags, tag}
    logic [PW-1:0] drv;
    logic [PW-1:0] obs;

    logic [PW-1:0] exp_q[$];
    int            exp_ptr;
    int            total;
    int            bad;

    assign iRESULT_WRITEBACK           = drv[54];
    assign iRESULT_DESTINATION_REGNAME = drv[53:48];
    assign iRESULT_DATA                = drv[47:16];
    assign iRESULT_FLAGS_OPT_VALID     = drv[15];
    assign iRESULT_FLAGS_REGNAME       = drv[14:11];
    assign iRESULT_FLAGS               = drv[10:6];
    assign iRESULT_COMMIT_TAG          = drv[5:0];

    assign obs = {oCDB_WRITEBACK, oCDB_DESTINATION_REGNAME, oCDB_DATA, oCDB_FLAGS_OPT_VALID,
                  oCDB_FLAGS_REGNAME, oCDB_FLAGS, oCDB_COMMIT_TAG};

    cdb_alu_transmitter #(.P_DEPTH(DEPTH)) dut (
        .iCLOCK                      (iCLOCK),
        .iRESET                      (iRESET),
        .iFLUSH                      (iFLUSH),
        .iISSUE_VALID                (iISSUE_VALID),
        .oEX_EXECUTION_POINTER       (oEX_EXECUTION_POINTER),
        .iRESULT_VALID               (iRESULT_VALID),
        .oRESULT_BUSY                (oRESULT_BUSY),
        .iRESULT_WRITEBACK           (iRESULT_WRITEBACK),
        .iRESULT_DESTINATION_REGNAME (iRESULT_DESTINATION_REGNAME),
        .iRESULT_DATA                (iRESULT_DATA),
        .iRESULT_FLAGS_OPT_VALID     (iRESULT_FLAGS_OPT_VALID),
        .iRESULT_FLAGS_REGNAME       (iRESULT_FLAGS_REGNAME),
        .iRESULT_FLAGS               (iRESULT_FLAGS),
        .iRESULT_COMMIT_TAG          (iRESULT_COMMIT_TAG),
        .iCDB_GRANT                  (iCDB_GRANT),
        .oCDB_VALID                  (oCDB_VALID),
        .oCDB_WRITEBACK              (oCDB_WRITEBACK),
        .oCDB_DESTINATION_REGNAME    (oCDB_DESTINATION_REGNAME),
        .oCDB_DATA                   (oCDB_DATA),
        .oCDB_FLAGS_OPT_VALID        (oCDB_FLAGS_OPT_VALID),
        .oCDB_FLAGS_REGNAME          (oCDB_FLAGS_REGNAME),
        .oCDB_FLAGS                  (oCDB_FLAGS),
        .oCDB_COMMIT_TAG             (oCDB_COMMIT_TAG),
        .oINFO_COUNT                 (oINFO_COUNT)
    );

    // Clock / reset
    always #5 iCLOCK = ~iCLOCK;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] rand_payload();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[PW-1:0];
    endfunction

    task automatic set_idle();
        iFLUSH        = 1'b0;
        iISSUE_VALID  = 1'b0;
        iRESULT_VALID = 1'b0;
        iCDB_GRANT    = 1'b0;
        drv           = '0;
    endtask

    // One clock: compare outputs mid-cycle against the model, then advance the
    // model with the inputs that the rising edge samples.
    task automatic cycle();
        logic          exp_busy;
        logic          exp_valid;
        logic [PW-1:0] exp_head;
        @(negedge iCLOCK);
        exp_busy  = (exp_q.size() == DEPTH);
        exp_valid = (exp_q.size() != 0) && iCDB_GRANT && !iFLUSH;
        exp_head  = (exp_q.size() != 0) ? exp_q[0] : '0;
        check("busy",    64'(oRESULT_BUSY),          64'(exp_busy));
        check("valid",   64'(oCDB_VALID),            64'(exp_valid));
        check("payload", 64'(obs),                   64'(exp_head));
        check("count",   64'(oINFO_COUNT),           64'(exp_q.size()));
        check("ex_ptr",  64'(oEX_EXECUTION_POINTER), 64'(exp_ptr));
        @(posedge iCLOCK);
        if (iFLUSH) begin
            exp_q.delete();
            exp_ptr = 0;
        end else begin
            if (exp_valid) void'(exp_q.pop_front());
            if (iRESULT_VALID && !exp_busy) exp_q.push_back(drv);
            if (iISSUE_VALID) exp_ptr = (exp_ptr + 1) % 16;
        end
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   64'(oCDB_VALID),            64'(0));
        check({tag, "_payload"}, 64'(obs),                   64'(0));
        check({tag, "_count"},   64'(oINFO_COUNT),           64'(0));
        check({tag, "_busy"},    64'(oRESULT_BUSY),          64'(0));
        check({tag, "_ex_ptr"},  64'(oEX_EXECUTION_POINTER), 64'(0));
    endtask

    task automatic drain();
        iRESULT_VALID = 1'b0;
        iCDB_GRANT    = 1'b1;
        for (int i = 0; i < 16 && exp_q.size() != 0; i++) cycle();
        iCDB_GRANT = 1'b0;
    endtask

    initial begin
        logic [PW-1:0] t1_pl;
        logic [PW-1:0] pl [5];
        total = 0;
        bad   = 0;
        exp_ptr = 0;
        set_idle();
        iRESET = 1'b1;
        #12;
        check_all_zero("reset");
        @(posedge iCLOCK);
        #1;
        iRESET = 1'b0;

        // Single result, grant held: broadcast exactly one cycle later
        t1_pl = {1'b1, 6'h05, 32'hDEADBEEF, 1'b0, 4'h0, 5'h00, 6'h00};
        drv = t1_pl;
        iRESULT_VALID = 1'b1;
        iCDB_GRANT = 1'b1;
        #1;
        check("single_no_bypass", 64'(oCDB_VALID), 64'(0));
        cycle();
        iRESULT_VALID = 1'b0;
        #1;
        check("single_valid", 64'(oCDB_VALID), 64'(1));
        check("single_payload", 64'(obs), 64'(t1_pl));
        cycle();
        #1;
        check("single_after", 64'(oCDB_VALID), 64'(0));
        cycle();

        // Fill with grant low, fifth push dropped, then drain in order
        set_idle();
        for (int i = 0; i < 5; i++) begin
            pl[i] = rand_payload();
            drv = pl[i];
            iRESULT_VALID = 1'b1;
            #1;
            check("fill_busy", 64'(oRESULT_BUSY), 64'(i == 4));
            cycle();
        end
        iRESULT_VALID = 1'b0;
        #1;
        check("fill_count", 64'(oINFO_COUNT), 64'(4));
        iCDB_GRANT = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_valid", 64'(oCDB_VALID), 64'(1));
            check("drain_order", 64'(obs), 64'(pl[i]));
            cycle();
        end
        #1;
        check("drain_empty", 64'(oCDB_VALID), 64'(0));
        cycle();

        // Full with simultaneous push and pop: push rejected, count drops to 3
        set_idle();
        for (int i = 0; i < 4; i++) begin
            drv = rand_payload();
            iRESULT_VALID = 1'b1;
            cycle();
        end
        drv = rand_payload();
        iCDB_GRANT = 1'b1;
        #1;
        check("full_pp_busy", 64'(oRESULT_BUSY), 64'(1));
        check("full_pp_valid", 64'(oCDB_VALID), 64'(1));
        cycle();
        iRESULT_VALID = 1'b0;
        iCDB_GRANT = 1'b0;
        #1;
        check("full_pp_count", 64'(oINFO_COUNT), 64'(3));
        drain();

        // Execution pointer wrap
        set_idle();
        iFLUSH = 1'b1;
        cycle();
        iFLUSH = 1'b0;
        iISSUE_VALID = 1'b1;
        for (int i = 0; i < 17; i++) cycle();
        iISSUE_VALID = 1'b0;
        #1;
        check("ptr_wrap", 64'(oEX_EXECUTION_POINTER), 64'(1));

        // Flush with count=3, pointer=7 and a competing push/pop/issue
        iFLUSH = 1'b1;
        cycle();
        iFLUSH = 1'b0;
        for (int i = 0; i < 7; i++) begin
            iISSUE_VALID = 1'b1;
            iRESULT_VALID = (i < 3);
            drv = rand_payload();
            cycle();
        end
        set_idle();
        #1;
        check("pre_flush_count", 64'(oINFO_COUNT), 64'(3));
        check("pre_flush_ptr", 64'(oEX_EXECUTION_POINTER), 64'(7));
        iFLUSH = 1'b1;
        iRESULT_VALID = 1'b1;
        iCDB_GRANT = 1'b1;
        iISSUE_VALID = 1'b1;
        drv = rand_payload();
        #1;
        check("flush_valid", 64'(oCDB_VALID), 64'(0));
        cycle();
        iFLUSH = 1'b0;
        iRESULT_VALID = 1'b0;
        iISSUE_VALID = 1'b0;
        #1;
        check("flush_count", 64'(oINFO_COUNT), 64'(0));
        check("flush_ptr", 64'(oEX_EXECUTION_POINTER), 64'(0));
        check("flush_cdb_valid", 64'(oCDB_VALID), 64'(0));
        cycle();

        // Asynchronous reset in the middle of a broadcast
        set_idle();
        for (int i = 0; i < 2; i++) begin
            drv = rand_payload();
            iRESULT_VALID = 1'b1;
            iISSUE_VALID = 1'b1;
            cycle();
        end
        set_idle();
        iCDB_GRANT = 1'b1;
        #1;
        check("pre_reset_valid", 64'(oCDB_VALID), 64'(1));
        iRESET = 1'b1;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        exp_ptr = 0;
        @(posedge iCLOCK);
        #1;
        iRESET = 1'b0;
        #1;
        check("post_reset_count", 64'(oINFO_COUNT), 64'(0));
        check("post_reset_valid", 64'(oCDB_VALID), 64'(0));
        cycle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            iFLUSH        = ($urandom_range(0, 31) == 0);
            iRESULT_VALID = ($urandom_range(0, 3) != 0);
            iCDB_GRANT    = $urandom_range(0, 1) == 1;
            iISSUE_VALID  = $urandom_range(0, 1) == 1;
            drv           = rand_payload();
            cycle();
        end
        set_idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
